// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver.
// 2-FF input synchroniser, 3-sample majority voting per bit, start-glitch
// rejection, optional parity, 1 or 2 stop bits, break detection and a
// valid/ready output holding register with an overrun pulse.
//
// Handshake: rx_valid rises when a frame commits and holds rx_data,
// parity_err and frame_err stable until a clock edge samples
// rx_valid & rx_ready. That edge consumes the word. A commit on the same
// edge as an accept reloads the register and rx_valid stays 1. A commit
// while rx_valid & !rx_ready drops the new frame and pulses overrun.
module uart_rx_cfg #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 break_det,
   output logic                 overrun,
   output logic                 busy,
   output logic [2:0]           state_dbg
);

   localparam int DIV  = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int TC_W = $clog2(DIV);
   localparam int SC_W = $clog2(OVERSAMPLE);

   localparam logic [TC_W-1:0] TC_MAX   = TC_W'(DIV - 1);
   localparam logic [SC_W-1:0] SC_V0    = SC_W'(OVERSAMPLE/2 - 1);
   localparam logic [SC_W-1:0] SC_V1    = SC_W'(OVERSAMPLE/2);
   localparam logic [SC_W-1:0] SC_DEC   = SC_W'(OVERSAMPLE/2 + 1);
   localparam logic [SC_W-1:0] SC_MAX   = SC_W'(OVERSAMPLE - 1);
   localparam logic [3:0]      BIT_LAST = 4'(DATA_BITS - 1);
   localparam logic            STOP_LAST = 1'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_PARITY    = 3'd3,
      S_STOP      = 3'd4,
      S_WAIT_IDLE = 3'd5
   } state_t;

   state_t               state;
   logic                 rx_m, rx_s;
   logic [TC_W-1:0]      tick_cnt;
   logic [SC_W-1:0]      sc;
   logic                 v0, v1;
   logic [DATA_BITS-1:0] shreg;
   logic [3:0]           bit_cnt;
   logic                 stop_cnt;
   logic                 pbit;
   logic                 ferr_acc;
   logic                 commit;
   logic [DATA_BITS-1:0] c_data;
   logic                 c_perr, c_ferr, c_brk;

   logic tick, decide, maj, start_edge, ferr_now, par_calc, perr_now;

   assign tick       = (tick_cnt == TC_MAX);
   assign decide     = tick && (sc == SC_DEC);
   assign maj        = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);
   assign start_edge = (state == S_IDLE) && !rx_s;
   assign ferr_now   = ferr_acc | ~maj;
   assign par_calc   = (^shreg) ^ pbit;
   assign perr_now   = (PARITY != 0) && (par_calc != (PARITY == 1));
   assign state_dbg  = state;

   // Two-flop synchroniser, preset to the idle line level
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   // Tick divider and per-bit sample counter, realigned on each start edge
   always_ff @(posedge clk) begin
      if (rst || start_edge) begin
         tick_cnt <= '0;
         sc       <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
         sc       <= (sc == SC_MAX) ? '0 : sc + 1'b1;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   // Capture the two early votes; the third is rx_s at the decision tick
   always_ff @(posedge clk) begin
      if (rst) begin
         v0 <= 1'b0;
         v1 <= 1'b0;
      end else if (tick) begin
         if (sc == SC_V0) v0 <= rx_s;
         if (sc == SC_V1) v1 <= rx_s;
      end
   end

   // Frame FSM: one decision per bit, commit request on the last stop bit
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         busy     <= 1'b0;
         shreg    <= '0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         pbit     <= 1'b0;
         ferr_acc <= 1'b0;
         commit   <= 1'b0;
         c_data   <= '0;
         c_perr   <= 1'b0;
         c_ferr   <= 1'b0;
         c_brk    <= 1'b0;
      end else begin
         commit <= 1'b0;
         case (state)
            S_IDLE: begin
               if (!rx_s) begin
                  busy  <= 1'b1;
                  state <= S_START;
               end
            end
            S_START: begin
               if (decide) begin
                  if (maj) begin
                     // Start bit did not survive the vote: a glitch
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end else begin
                     bit_cnt <= '0;
                     state   <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (decide) begin
                  shreg <= {maj, shreg[DATA_BITS-1:1]};
                  if (bit_cnt == BIT_LAST) begin
                     pbit     <= 1'b0;
                     stop_cnt <= 1'b0;
                     ferr_acc <= 1'b0;
                     state    <= (PARITY != 0) ? S_PARITY : S_STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            S_PARITY: begin
               if (decide) begin
                  pbit  <= maj;
                  state <= S_STOP;
               end
            end
            S_STOP: begin
               if (decide) begin
                  if (stop_cnt == STOP_LAST) begin
                     commit <= 1'b1;
                     c_data <= shreg;
                     c_perr <= perr_now;
                     c_ferr <= ferr_now;
                     c_brk  <= ferr_now && (shreg == '0) && !pbit;
                     // A bad stop bit waits for the line to go idle so a
                     // held-low line yields exactly one frame
                     if (ferr_now) begin
                        state <= S_WAIT_IDLE;
                     end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                     end
                  end else begin
                     ferr_acc <= ferr_now;
                     stop_cnt <= stop_cnt + 1'b1;
                  end
               end
            end
            S_WAIT_IDLE: begin
               if (rx_s) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Output holding register with accept, commit, overrun and break pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         break_det  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         break_det <= 1'b0;
         overrun   <= 1'b0;
         if (rx_valid && rx_ready) rx_valid <= 1'b0;
         if (commit) begin
            break_det <= c_brk;
            if (rx_valid && !rx_ready) begin
               overrun <= 1'b1;
            end else begin
               rx_data    <= c_data;
               parity_err <= c_perr;
               frame_err  <= c_ferr;
               rx_valid   <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: an 8N1 instance with a scoreboard on its
// accepted words and an 8E1 instance for parity checks. One bit = 160 clk.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

   localparam int BIT = 160;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       rx_a, rdy_a, rx_p, rdy_p;
   logic [7:0] a_data, p_data;
   logic       a_valid, a_perr, a_ferr, a_brk, a_ovr, a_busy;
   logic       p_valid, p_perr, p_ferr, p_brk, p_ovr, p_busy;
   logic [2:0] a_state, p_state;

   uart_rx_cfg #(
      .CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLE(16),
      .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
   ) dut_a (
      .clk(clk), .rst(rst), .rx(rx_a), .rx_data(a_data), .rx_valid(a_valid),
      .rx_ready(rdy_a), .parity_err(a_perr), .frame_err(a_ferr),
      .break_det(a_brk), .overrun(a_ovr), .busy(a_busy), .state_dbg(a_state)
   );

   uart_rx_cfg #(
      .CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLE(16),
      .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
   ) dut_p (
      .clk(clk), .rst(rst), .rx(rx_p), .rx_data(p_data), .rx_valid(p_valid),
      .rx_ready(rdy_p), .parity_err(p_perr), .frame_err(p_ferr),
      .break_det(p_brk), .overrun(p_ovr), .busy(p_busy), .state_dbg(p_state)
   );

   // ---------------- checking ----------------
   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- scoreboard on dut_a: {frame_err, parity_err, data} ----------------
   logic [9:0] exp_q[$];
   int acc_cnt = 0;
   int brk_cnt = 0;
   int ovr_cnt = 0;

   always @(negedge clk) begin
      if (!rst) begin
         if (a_valid && rdy_a) begin
            acc_cnt++;
            if (exp_q.size() == 0) begin
               chk("sb_unexpected_frame", {22'd0, a_ferr, a_perr, a_data}, 32'hFFFF_FFFF);
            end else begin
               logic [9:0] e;
               e = exp_q.pop_front();
               chk("sb_frame", {22'd0, a_ferr, a_perr, a_data}, {22'd0, e});
            end
         end
         if (a_brk) brk_cnt++;
         if (a_ovr) ovr_cnt++;
      end
   end

   // ---------------- drivers ----------------
   task automatic line(input bit p, input logic v, input int n);
      if (p) rx_p = v; else rx_a = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input bit p, input logic [7:0] d, input bit par_en,
                             input logic pb, input logic stop_v);
      line(p, 1'b0, BIT);
      for (int i = 0; i < 8; i++) line(p, d[i], BIT);
      if (par_en) line(p, pb, BIT);
      line(p, stop_v, BIT);
   endtask

   task automatic wait_valid(input bit p, input int max, output int n);
      n = 0;
      while (((p ? p_valid : a_valid) == 1'b0) && (n < max)) begin
         @(negedge clk);
         n++;
      end
   endtask

   // Watchdog: any hang ends the run with a reported failure
   initial begin
      #600_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int n, c0, b0, o0;
      logic [7:0] d;
      rst = 1'b1; rx_a = 1'b1; rx_p = 1'b1; rdy_a = 1'b1; rdy_p = 1'b0;
      repeat (3) @(negedge clk);

      // Reset values
      chk("rst_valid", a_valid, 0);
      chk("rst_data", a_data, 0);
      chk("rst_perr", a_perr, 0);
      chk("rst_ferr", a_ferr, 0);
      chk("rst_brk", a_brk, 0);
      chk("rst_ovr", a_ovr, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_state", a_state, 0);
      chk("rst_p_outs", {p_valid, p_perr, p_ferr, p_brk, p_ovr, p_busy, p_state}, 0);
      rst = 1'b0;
      line(0, 1'b1, 20);

      // 1. 8N1 0xA5, valid within one bit of the stop-bit start
      d = 8'hA5;
      exp_q.push_back({2'b00, 8'hA5});
      line(0, 1'b0, BIT);
      chk("t1_busy_mid", a_busy, 1);
      for (int i = 0; i < 8; i++) line(0, d[i], BIT);
      rx_a = 1'b1;
      wait_valid(0, BIT, n);
      chk("t1_latency_ok", n < BIT, 1);
      line(0, 1'b1, BIT);
      chk("t1_busy_after", a_busy, 0);

      // 2. Even parity on dut_p: 0x3C with pbit=1 is a parity error, pbit=0 is clean
      send_frame(1, 8'h3C, 1, 1'b1, 1'b1);
      chk("t2_valid", p_valid, 1);
      chk("t2_data", p_data, 8'h3C);
      chk("t2_perr", p_perr, 1);
      chk("t2_ferr", p_ferr, 0);
      @(posedge clk); #1 rdy_p = 1'b1;
      @(posedge clk); #1 rdy_p = 1'b0;
      @(negedge clk);
      chk("t2_accept_clears", p_valid, 0);
      line(1, 1'b1, BIT);
      send_frame(1, 8'h3C, 1, 1'b0, 1'b1);
      chk("t2b_data", p_data, 8'h3C);
      chk("t2b_perr", p_perr, 0);
      chk("t2b_valid", p_valid, 1);

      // 3. Stop bit 0: frame error, busy held until the line returns high
      exp_q.push_back({2'b10, 8'h55});
      send_frame(0, 8'h55, 0, 1'b0, 1'b0);
      line(0, 1'b0, 2 * BIT);
      chk("t3_busy_held", a_busy, 1);
      chk("t3_wait_idle", a_state, 5);
      line(0, 1'b1, 5);
      chk("t3_busy_release", a_busy, 0);
      line(0, 1'b1, BIT);
      exp_q.push_back({2'b00, 8'h12});
      send_frame(0, 8'h12, 0, 1'b0, 1'b1);
      line(0, 1'b1, BIT);

      // 4. Line held low for 20 bits: one break, one frame
      b0 = brk_cnt; c0 = acc_cnt; o0 = ovr_cnt;
      exp_q.push_back({2'b10, 8'h00});
      line(0, 1'b0, 20 * BIT);
      line(0, 1'b1, 2 * BIT);
      chk("t4_one_break", brk_cnt - b0, 1);
      chk("t4_one_frame", acc_cnt - c0, 1);
      chk("t4_no_overrun", ovr_cnt - o0, 0);

      // 5a. 30-clock start glitch is rejected
      c0 = acc_cnt;
      line(0, 1'b0, 30);
      chk("t5_glitch_busy", a_busy, 1);
      line(0, 1'b1, 100);
      chk("t5_glitch_busy_drop", a_busy, 0);
      chk("t5_glitch_no_frame", acc_cnt - c0, 0);
      line(0, 1'b1, BIT);

      // 5b. 0xF0 with a 10-clock high pulse over the middle vote of bit 0
      d = 8'hF0;
      exp_q.push_back({2'b00, 8'hF0});
      line(0, 1'b0, BIT);
      line(0, 1'b0, 85);
      line(0, 1'b1, 10);
      line(0, 1'b0, 65);
      for (int i = 1; i < 8; i++) line(0, d[i], BIT);
      line(0, 1'b1, BIT);
      line(0, 1'b1, BIT);

      // 6. Consumer stalled: second frame overruns, held word kept
      rdy_a = 1'b0;
      o0 = ovr_cnt;
      exp_q.push_back({2'b00, 8'hA5});
      send_frame(0, 8'hA5, 0, 1'b0, 1'b1);
      line(0, 1'b1, BIT);
      send_frame(0, 8'h5A, 0, 1'b0, 1'b1);
      line(0, 1'b1, BIT);
      chk("t6_one_overrun", ovr_cnt - o0, 1);
      chk("t6_held_data", a_data, 8'hA5);
      chk("t6_still_valid", a_valid, 1);
      @(posedge clk); #1 rdy_a = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("t6_valid_clears", a_valid, 0);

      // 6b. Reset mid-frame, then a clean frame
      line(0, 1'b0, BIT);
      line(0, 1'b1, BIT);
      line(0, 1'b0, 50);
      chk("t6r_busy_mid", a_busy, 1);
      rst = 1'b1; rx_a = 1'b1;
      repeat (2) @(negedge clk);
      chk("t6r_outs", {a_valid, a_perr, a_ferr, a_brk, a_ovr, a_busy}, 0);
      chk("t6r_data", a_data, 0);
      chk("t6r_state", a_state, 0);
      rst = 1'b0;
      line(0, 1'b1, 2 * BIT);
      exp_q.push_back({2'b00, 8'h3C});
      send_frame(0, 8'h3C, 0, 1'b0, 1'b1);
      line(0, 1'b1, BIT);

      // Final accounting
      repeat (10) @(negedge clk);
      chk("sb_drained", exp_q.size(), 0);
      chk("total_accepts", acc_cnt, 7);
      chk("total_breaks", brk_cnt, 1);
      chk("total_overruns", ovr_cnt, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
